// File: rtl/tl_pkg.sv
// Shared defaults, emergency FSM encoding and counter sizing helper for the
// traffic-light input conditioner.
package tl_pkg;

  localparam int TL_CLK_HZ       = 100_000_000;
  localparam int TL_DEBOUNCE_CYC = 1_000_000;
  localparam int TL_EV_HOLD_S    = 4;

  typedef enum logic [1:0] {
    EV_IDLE   = 2'd0,
    EV_ACTIVE = 2'd1,
    EV_HOLD   = 2'd2
  } ev_state_t;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tl_input_conditioner_if.sv
// Raw sensor inputs and conditioned outputs of the input conditioner.
interface tl_input_conditioner_if;

  logic ev_req_raw;
  logic mains_ok_raw;
  logic pulse_1s;
  logic nmi_emergency_vehicle;
  logic nmi_power_outage;
  logic ev_event;

  modport master (
    output ev_req_raw,
    output mains_ok_raw,
    input  pulse_1s,
    input  nmi_emergency_vehicle,
    input  nmi_power_outage,
    input  ev_event
  );

  modport slave (
    input  ev_req_raw,
    input  mains_ok_raw,
    output pulse_1s,
    output nmi_emergency_vehicle,
    output nmi_power_outage,
    output ev_event
  );

endinterface

// File: rtl/tl_debounce.sv
// Two-flop synchronizer followed by a stability filter: the filtered value
// follows the synchronized input only after DEBOUNCE_CYC disagreeing cycles.
module tl_debounce
  import tl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = TL_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Filter stage: the last disagreeing cycle toggles instead of counting on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_p1 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      filt <= ~filt;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tl_input_conditioner.sv
// Input conditioner: 1 s prescaler, debounced emergency/mains sensing and an
// emergency-vehicle FSM that holds the NMI for EV_HOLD_S seconds after release.
module tl_input_conditioner
  import tl_pkg::*;
#(
  parameter int CLK_HZ       = TL_CLK_HZ,
  parameter int DEBOUNCE_CYC = TL_DEBOUNCE_CYC,
  parameter int EV_HOLD_S    = TL_EV_HOLD_S
) (
  input logic                   clk,
  input logic                   reset_n,
  tl_input_conditioner_if.slave io
);

  localparam int PRE_W  = cnt_w(CLK_HZ - 1);
  localparam int HOLD_W = cnt_w(EV_HOLD_S);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(EV_HOLD_S);

  logic [PRE_W-1:0]  pre_cnt;
  logic              pulse;
  logic              ev_filt;
  logic              ev_filt_p1;
  logic              mains_filt;
  logic              ev_rise;
  logic              ev_fall;
  ev_state_t         state;
  ev_state_t         state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              nmi_ev;
  logic              outage;
  logic              ev_strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pulse   <= 1'b0;
    end else begin
      pulse   <= (pre_cnt == PRE_LAST);
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end

  tl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ev_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (io.ev_req_raw),
    .filt    (ev_filt)
  );

  tl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mains_db (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (io.mains_ok_raw),
    .filt    (mains_filt)
  );

  // Edge stage: filtered-level history for rise/fall detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_filt_p1 <= 1'b0;
    end else begin
      ev_filt_p1 <= ev_filt;
    end
  end

  assign ev_rise = ev_filt & ~ev_filt_p1;
  assign ev_fall = ~ev_filt & ev_filt_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EV_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // A fall always reloads the hold time; a coincident pulse_1s is not counted.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    unique case (state)
      EV_IDLE: begin
        if (ev_rise) state_nxt = EV_ACTIVE;
      end
      EV_ACTIVE: begin
        if (ev_fall) begin
          if (EV_HOLD_S == 0) begin
            state_nxt = EV_IDLE;
          end else begin
            state_nxt = EV_HOLD;
            hold_nxt  = HOLD_LOAD;
          end
        end
      end
      EV_HOLD: begin
        if (ev_rise) begin
          state_nxt = EV_ACTIVE;
        end else if (hold_cnt == '0) begin
          state_nxt = EV_IDLE;
        end else if (pulse) begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      default: state_nxt = EV_IDLE;
    endcase
  end

  // Output stage: outage reads as asserted until mains has debounced good.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_ev    <= 1'b0;
      ev_strobe <= 1'b0;
      outage    <= 1'b1;
    end else begin
      nmi_ev    <= (state_nxt != EV_IDLE);
      ev_strobe <= ev_rise;
      outage    <= ~mains_filt;
    end
  end

  assign io.pulse_1s              = pulse;
  assign io.nmi_emergency_vehicle = nmi_ev;
  assign io.nmi_power_outage      = outage;
  assign io.ev_event              = ev_strobe;

endmodule

// File: doc/tl_input_conditioner.md
TL_INPUT_CONDITIONER -- requirements
Module: tl_input_conditioner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000: clk cycles per pulse_1s period.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 1000000: consecutive stable clk cycles for a debounced input to change.
REQ-003 SHALL have parameter EV_HOLD_S, default 4: pulse_1s periods nmi_emergency_vehicle is held after the request releases.
REQ-004 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ev_req_raw  input  1  asynchronous emergency-vehicle detector, active high, may bounce.
REQ-007 SHALL have port mains_ok_raw  input  1  asynchronous mains-good sense, active high, may bounce.
REQ-008 SHALL have port pulse_1s  output  1  one-clk-wide strobe, once per CLK_HZ cycles.
REQ-009 SHALL have port nmi_emergency_vehicle  output  1  registered, conditioned emergency request.
REQ-010 SHALL have port nmi_power_outage  output  1  registered, conditioned outage flag.
REQ-011 SHALL have port ev_event  output  1  one-clk strobe on each debounced rising edge of ev_req_raw.

Function
REQ-012 SHALL count a prescaler 0..CLK_HZ-1, wrapping to 0; pulse_1s SHALL be high exactly in the cycle following the edge where the count equals CLK_HZ-1; first pulse_1s occurs CLK_HZ edges after reset release.
REQ-013 SHALL pass each raw input through a two-flop synchronizer; no other logic SHALL sample raw inputs.
REQ-014 SHALL debounce each synchronized input: counter increments while synchronized value differs from filtered value, clears to 0 on any agreeing cycle; filtered value SHALL toggle, and counter clear, on the edge where counter reaches DEBOUNCE_CYC.
REQ-015 SHALL change outputs exactly DEBOUNCE_CYC+3 clk edges after a raw input change held stable; glitches shorter than DEBOUNCE_CYC synchronized cycles SHALL have no output effect.
REQ-016 SHALL drive nmi_power_outage as registered inverse of filtered mains_ok.
REQ-017 SHALL implement emergency FSM states EV_IDLE, EV_ACTIVE, EV_HOLD.
REQ-018 EV_IDLE -> EV_ACTIVE when filtered ev rises; EV_ACTIVE -> EV_HOLD when filtered ev falls, loading hold counter with EV_HOLD_S; EV_HOLD decrements on pulse_1s, -> EV_IDLE when counter is 0; EV_HOLD -> EV_ACTIVE if filtered ev rises again (hold restarts on next fall).
REQ-019 If EV_HOLD_S is 0, EV_ACTIVE SHALL go directly to EV_IDLE on filtered fall.
REQ-020 nmi_emergency_vehicle SHALL be high in EV_ACTIVE and EV_HOLD, low in EV_IDLE, registered.
REQ-021 ev_event SHALL pulse on every filtered ev rising edge, including re-rise during EV_HOLD, aligned with nmi_emergency_vehicle output timing.
REQ-022 Filtered fall coinciding with pulse_1s SHALL load hold counter with EV_HOLD_S (the pulse is not counted).
REQ-023 Hold counter width SHALL be sized from EV_HOLD_S; prescaler and debounce counter widths from CLK_HZ and DEBOUNCE_CYC, no overflow.

Reset
REQ-024 reset_n low SHALL immediately clear prescaler, debounce counters, synchronizers, filtered values (0), hold counter, FSM (EV_IDLE).
REQ-025 During reset: pulse_1s=0, nmi_emergency_vehicle=0, ev_event=0, nmi_power_outage=1 (fail-safe: outage reported until mains debounced good).
REQ-026 Reset asserted mid-hold or mid-debounce SHALL discard all progress; no strobe SHALL emit on reset release.

Structure
REQ-027 Shared package tl_pkg SHALL hold default CLK_HZ, DEBOUNCE_CYC, EV_HOLD_S and EV FSM state encodings.
REQ-028 Debounce SHALL be a sub-module tl_debounce (synchronizer + filter, parameter DEBOUNCE_CYC, reset value 0), instantiated twice.

Verification (CLK_HZ=20, DEBOUNCE_CYC=4, EV_HOLD_S=2)
REQ-029 Release reset, run 100 cycles -> pulse_1s high at edges 20,40,60,80,100, each one cycle wide.
REQ-030 mains_ok_raw=1 from reset release -> nmi_power_outage falls at edge 7; 3-cycle low glitch later -> no change; 5-cycle low -> nmi_power_outage high 7 edges after glitch start.
REQ-031 ev_req_raw high 10 cycles -> nmi_emergency_vehicle and ev_event rise together 7 edges later; after release, nmi stays high until the 2nd subsequent pulse_1s with state EV_HOLD, then low.
REQ-032 ev_req_raw re-asserted during EV_HOLD -> second ev_event, nmi stays high continuously, hold restarts after next release.
REQ-033 reset_n low for 1 cycle during EV_HOLD -> nmi_emergency_vehicle=0 and nmi_power_outage=1 immediately; no ev_event after release.
